// File: rtl/d_reg_rr_arbiter_if.sv
// rtl/d_reg_rr_arbiter_if.sv - requester/register bundle for the round-robin D register arbiter
interface d_reg_rr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       REQ;
    logic [NREQ-1:0]       LOCK;
    logic [NREQ*WIDTH-1:0] D_IN;
    logic                  CLR;
    logic [WIDTH-1:0]      Q;
    logic [NREQ-1:0]       GNT;
    logic [IDW-1:0]        OWNER;
    logic                  VALID;
    logic                  LOCKED;

    modport master (
        output REQ, LOCK, D_IN, CLR,
        input  Q, GNT, OWNER, VALID, LOCKED
    );

    modport slave (
        input  REQ, LOCK, D_IN, CLR,
        output Q, GNT, OWNER, VALID, LOCKED
    );
endinterface

// File: rtl/d_reg_rr_arbiter.sv
// rtl/d_reg_rr_arbiter.sv - round-robin, lockable write arbiter in front of a shared D register
module d_reg_rr_arbiter #(
    parameter int  NREQ  = 4,
    parameter int  WIDTH = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    d_reg_rr_arbiter_if.slave    bus
);
    typedef enum logic {S_OPEN, S_LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             valid_q, valid_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;

    // Wraps at NREQ-1 explicitly so non-power-of-two NREQ never yields an out-of-range index.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (i == IDW'(NREQ - 1)) ? '0 : i + IDW'(1);
    endfunction

    // Scan from the highest offset down so the closest requester to ptr_q is written last.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_w;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_w = IDW'(idx);
            if (bus.REQ[idx_w]) begin
                win_found = 1'b1;
                win_idx   = idx_w;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        gnt_d   = '0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        if (bus.CLR) begin
            q_d     = '0;
            valid_d = 1'b0;
            state_d = S_OPEN;
        end else begin
            case (state_q)
                S_OPEN: begin
                    if (win_found) begin
                        q_d            = bus.D_IN[win_idx*WIDTH +: WIDTH];
                        gnt_d[win_idx] = 1'b1;
                        owner_d        = win_idx;
                        valid_d        = 1'b1;
                        ptr_d          = next_idx(win_idx);
                        if (bus.LOCK[win_idx]) begin
                            state_d = S_LOCKED;
                        end
                    end
                end
                S_LOCKED: begin
                    if (bus.REQ[owner_q]) begin
                        q_d            = bus.D_IN[owner_q*WIDTH +: WIDTH];
                        gnt_d[owner_q] = 1'b1;
                        valid_d        = 1'b1;
                    end
                    // Releasing the lock still lets the final write in this cycle land.
                    if (!bus.LOCK[owner_q]) begin
                        state_d = S_OPEN;
                        ptr_d   = next_idx(owner_q);
                    end
                end
                default: state_d = S_OPEN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_OPEN;
            q_q     <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Q      = q_q;
    assign bus.GNT    = gnt_q;
    assign bus.OWNER  = owner_q;
    assign bus.VALID  = valid_q;
    assign bus.LOCKED = (state_q == S_LOCKED);
endmodule
